// File: rtl/mem_responder.sv
// Word RAM responder: fixed-latency RAM path plus an optional handshaked IO path.
// Build macro MEM_RESPONDER_IO_EN enables the IO path; without it IO accesses complete immediately and are dropped.
module mem_responder #(
  parameter int RV   = 16,
  parameter int VA   = RV,
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [VA-1:1] addr,
  input  logic [RV-1:0] wdata,
  input  logic [1:0]    wmask,
  input  logic [1:0]    rstrobe,
  input  logic          ifetch,
  input  logic          io_access,
  output logic          idone,
  output logic          rdone,
  output logic          wdone,
  output logic [RV-1:0] rdata,
  output logic          io_req,
  output logic          io_we,
  output logic [VA-1:1] io_addr,
  output logic [RV-1:0] io_wdata,
  output logic [1:0]    io_wmask,
  input  logic          io_ready,
  input  logic [RV-1:0] io_rdata
);

  // state  | meaning
  // IDLE   | sampling requests (write > read > fetch)
  // BUSY   | RAM latency countdown, WAIT cycles
  // IOWAIT | io_req held until io_ready (IO build only)
  // DONE   | one-cycle done pulse; RAM write commits on its closing edge
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
`ifdef MEM_RESPONDER_IO_EN
    IOWAIT = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] K_WRITE = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_FETCH = 2'd2;

  function automatic logic [RV-1:0] f_steer(input logic [1:0] strobe, input logic [RV-1:0] word);
    case (strobe)
      2'b01:   f_steer = {8'h00, word[7:0]};
      2'b10:   f_steer = {8'h00, word[15:8]};
      default: f_steer = word;
    endcase
  endfunction

  logic [RV-1:0] r_mem [0:(1<<AW)-1];

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_kind;
  logic [VA-1:1] r_addr;
  logic [RV-1:0] r_wdata;
  logic [1:0]    r_wmask;
  logic [1:0]    r_rstrobe;
  logic          r_io;
  logic [2:0]    r_wait_cnt;
  logic [RV-1:0] r_rdata;

  logic          w_req;
  logic [1:0]    w_kind_in;
  logic          w_io_in;
  logic          w_sample;
  logic          w_enter_done;
  logic          w_commit;
  logic [1:0]    w_kind_cur;
  logic [1:0]    w_strobe_cur;
  logic          w_io_cur;
  logic [AW-1:0] w_idx;
  logic [RV-1:0] w_load_val;

  always_comb begin
    w_req     = (|wmask) || (|rstrobe) || ifetch;
    w_kind_in = K_FETCH;
    if (|wmask)        w_kind_in = K_WRITE;
    else if (|rstrobe) w_kind_in = K_READ;
    w_io_in   = io_access && (w_kind_in != K_FETCH);
    w_sample  = (r_state == IDLE) && w_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_io_in) begin
`ifdef MEM_RESPONDER_IO_EN
            w_state_nxt = IOWAIT;
`else
            w_state_nxt = DONE;
`endif
          end else if (WAIT == 0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY:   if (r_wait_cnt == 3'd0) w_state_nxt = DONE;
`ifdef MEM_RESPONDER_IO_EN
      IOWAIT: if (io_ready) w_state_nxt = DONE;
`endif
      DONE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // With WAIT=0 the result is loaded on the sampling edge, so look at the live request in IDLE.
  always_comb begin
    if (r_state == IDLE) begin
      w_kind_cur   = w_kind_in;
      w_strobe_cur = (w_kind_in == K_FETCH) ? 2'b11 : rstrobe;
      w_io_cur     = w_io_in;
      w_idx        = addr[AW:1];
    end else begin
      w_kind_cur   = r_kind;
      w_strobe_cur = r_rstrobe;
      w_io_cur     = r_io;
      w_idx        = r_addr[AW:1];
    end
    w_enter_done = (w_state_nxt == DONE) && (r_state != DONE);
`ifdef MEM_RESPONDER_IO_EN
    w_load_val = w_io_cur ? f_steer(w_strobe_cur, io_rdata) : f_steer(w_strobe_cur, r_mem[w_idx]);
`else
    w_load_val = w_io_cur ? '0 : f_steer(w_strobe_cur, r_mem[w_idx]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_kind     <= K_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_rstrobe  <= '0;
      r_io       <= 1'b0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_sample) begin
        r_kind     <= w_kind_in;
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_wmask    <= wmask;
        r_rstrobe  <= (w_kind_in == K_FETCH) ? 2'b11 : rstrobe;
        r_io       <= w_io_in;
        r_wait_cnt <= (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);
      end else if ((r_state == BUSY) && (r_wait_cnt != 3'd0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
      if (w_enter_done && (w_kind_cur != K_WRITE)) r_rdata <= w_load_val;
    end
  end

  // RAM has no reset; a reset in DONE suppresses the commit so aborted writes leave no trace.
  assign w_commit = reset && (r_state == DONE) && (r_kind == K_WRITE) && !r_io;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (r_wmask[0]) r_mem[r_addr[AW:1]][7:0]  <= r_wdata[7:0];
      if (r_wmask[1]) r_mem[r_addr[AW:1]][15:8] <= r_wdata[15:8];
    end
  end

  assign wdone = (r_state == DONE) && (r_kind == K_WRITE);
  assign rdone = (r_state == DONE) && (r_kind == K_READ);
  assign idone = (r_state == DONE) && (r_kind == K_FETCH);
  assign rdata = r_rdata;

`ifdef MEM_RESPONDER_IO_EN
  assign io_req   = (r_state == IOWAIT);
  assign io_we    = io_req && (r_kind == K_WRITE);
  assign io_addr  = r_addr;
  assign io_wdata = r_wdata;
  assign io_wmask = io_req ? r_wmask : 2'b00;
`else
  logic w_unused;
  assign io_req   = 1'b0;
  assign io_we    = 1'b0;
  assign io_addr  = '0;
  assign io_wdata = '0;
  assign io_wmask = 2'b00;
  assign w_unused = ^{io_ready, io_rdata, r_addr[VA-1:AW+1]};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT 0/3/5) share stimulus, selected by sel.
// Scoreboard queue holds expected done type, rdata and latency per request.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:1] addr;
  logic [15:0] wdata;
  logic [1:0]  wmask, rstrobe;
  logic        ifetch, io_access, io_ready;
  logic [15:0] io_rdata;
  logic [1:0]  sel;

  logic [2:0]  idone_v, rdone_v, wdone_v, io_req_v, io_we_v;
  logic [15:0] rdata_v    [3];
  logic [15:1] io_addr_v  [3];
  logic [15:0] io_wdata_v [3];
  logic [1:0]  io_wmask_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.RV(16), .VA(16), .AW(10), .WAIT((g == 0) ? 0 : ((g == 1) ? 3 : 5))) u_dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .wmask     ((sel == 2'(g)) ? wmask : 2'b00),
      .rstrobe   ((sel == 2'(g)) ? rstrobe : 2'b00),
      .ifetch    ((sel == 2'(g)) && ifetch),
      .io_access (io_access),
      .idone     (idone_v[g]),
      .rdone     (rdone_v[g]),
      .wdone     (wdone_v[g]),
      .rdata     (rdata_v[g]),
      .io_req    (io_req_v[g]),
      .io_we     (io_we_v[g]),
      .io_addr   (io_addr_v[g]),
      .io_wdata  (io_wdata_v[g]),
      .io_wmask  (io_wmask_v[g]),
      .io_ready  ((sel == 2'(g)) && io_ready),
      .io_rdata  (io_rdata)
    );
  end

  logic        c_idone, c_rdone, c_wdone, c_ioreq, c_iowe;
  logic [15:0] c_rdata, c_iowdata;
  logic [15:1] c_ioaddr;
  logic [1:0]  c_iowmask;
  always_comb begin
    c_idone   = idone_v[sel];
    c_rdone   = rdone_v[sel];
    c_wdone   = wdone_v[sel];
    c_ioreq   = io_req_v[sel];
    c_iowe    = io_we_v[sel];
    c_rdata   = rdata_v[sel];
    c_ioaddr  = io_addr_v[sel];
    c_iowdata = io_wdata_v[sel];
    c_iowmask = io_wmask_v[sel];
  end

  typedef struct {
    logic [2:0]  done;   // {wdone, rdone, idone}
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mdl [3][1024];
  logic [15:0] last_rdata [3];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        io_seen;

  function automatic int wait_of(input logic [1:0] s);
    case (s)
      2'd0:    wait_of = 0;
      2'd1:    wait_of = 3;
      default: wait_of = 5;
    endcase
  endfunction

  function automatic logic [15:0] tb_steer(input logic [1:0] s, input logic [15:0] w);
    if (s == 2'b01)      tb_steer = {8'h00, w[7:0]};
    else if (s == 2'b10) tb_steer = {8'h00, w[15:8]};
    else                 tb_steer = w;
  endfunction

  task automatic drop_inputs();
    wmask = 2'b00; rstrobe = 2'b00; ifetch = 1'b0; io_access = 1'b0;
  endtask

  task automatic do_access(input string nm, input logic [1:0] sl, input logic [1:0] wm,
                           input logic [1:0] rs, input logic ft, input logic io,
                           input logic [15:1] a, input logic [15:0] wd, input int lat);
    exp_t e;
    int cyc;
    logic got;
    logic [15:0] w;
    sel = sl;
    w = mdl[sl][a[10:1]];
    if (wm != 2'b00) begin
      e.done = 3'b100; e.data = last_rdata[sl];
      if (!io) begin
        if (wm[0]) mdl[sl][a[10:1]][7:0]  = wd[7:0];
        if (wm[1]) mdl[sl][a[10:1]][15:8] = wd[15:8];
      end
    end else if (rs != 2'b00) begin
      e.done = 3'b010; e.data = io ? 16'h0000 : tb_steer(rs, w);
    end else begin
      e.done = 3'b001; e.data = w;
    end
    last_rdata[sl] = e.data;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    addr = a; wdata = wd; wmask = wm; rstrobe = rs; ifetch = ft; io_access = io;
    @(posedge clk);
    cyc = 0; got = 1'b0; io_seen = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (c_ioreq) io_seen = 1'b1;
      if (c_wdone | c_rdone | c_idone) got = 1'b1;
    end
    drop_inputs();
    e = sb.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no done within %0d cycles, required one", nm, cyc);
    end else begin
      n_checks++;
      if (cyc !== e.lat) begin
        n_fail++; $display("FAIL %s latency: got %0d required %0d", nm, cyc, e.lat);
      end
      n_checks++;
      if ({c_wdone, c_rdone, c_idone} !== e.done) begin
        n_fail++; $display("FAIL %s done {w,r,i}: got %b required %b", nm, {c_wdone, c_rdone, c_idone}, e.done);
      end
      n_checks++;
      if (c_rdata !== e.data) begin
        n_fail++; $display("FAIL %s rdata: got %h required %h", nm, c_rdata, e.data);
      end
      @(negedge clk);
      n_checks++;
      if ({c_wdone, c_rdone, c_idone} !== 3'b000) begin
        n_fail++; $display("FAIL %s pulse width: done still %b next cycle, required 000", nm, {c_wdone, c_rdone, c_idone});
      end
    end
  endtask

  task automatic test_reset();
    sel = 2'd0; drop_inputs(); io_ready = 1'b0; io_rdata = '0; addr = '0; wdata = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({idone_v[g], rdone_v[g], wdone_v[g], io_req_v[g], io_we_v[g], io_wmask_v[g]} !== 7'b0) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: got %b required 0", g,
                           {idone_v[g], rdone_v[g], wdone_v[g], io_req_v[g], io_we_v[g], io_wmask_v[g]});
      end
      n_checks++;
      if (rdata_v[g] !== 16'h0000) begin
        n_fail++; $display("FAIL reset_rdata[%0d]: got %h required 0000", g, rdata_v[g]);
      end
      last_rdata[g] = 16'h0000;
    end
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    do_access("w0_write",  2'd0, 2'b11, 2'b00, 1'b0, 1'b0, 15'h0010, 16'hBEEF, 1);
    do_access("w0_read",   2'd0, 2'b00, 2'b11, 1'b0, 1'b0, 15'h0010, 16'h0000, 1);
    n_checks++;
    if (c_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL w0_read_const: got %h required beef", c_rdata);
    end
    do_access("w0_fetch",  2'd0, 2'b00, 2'b00, 1'b1, 1'b1, 15'h0010, 16'h0000, 1);
    do_access("alias_wr",  2'd0, 2'b11, 2'b00, 1'b0, 1'b0, 15'h0433, 16'h7E7E, 1);
    do_access("alias_rd",  2'd0, 2'b00, 2'b11, 1'b0, 1'b0, 15'h0033, 16'h0000, 1);
  endtask

  task automatic test_byte_lanes();
    do_access("w3_init",   2'd1, 2'b11, 2'b00, 1'b0, 1'b0, 15'h0020, 16'h1234, 4);
    do_access("w3_hiwr",   2'd1, 2'b10, 2'b00, 1'b0, 1'b0, 15'h0020, 16'h5A5A, 4);
    do_access("w3_rd_hi",  2'd1, 2'b00, 2'b10, 1'b0, 1'b0, 15'h0020, 16'h0000, 4);
    n_checks++;
    if (c_rdata !== 16'h005A) begin
      n_fail++; $display("FAIL w3_rd_hi_const: got %h required 005a", c_rdata);
    end
    do_access("w3_rd_lo",  2'd1, 2'b00, 2'b01, 1'b0, 1'b0, 15'h0020, 16'h0000, 4);
    n_checks++;
    if (c_rdata !== 16'h0034) begin
      n_fail++; $display("FAIL w3_rd_lo_const: got %h required 0034", c_rdata);
    end
    do_access("w3_lowr",   2'd1, 2'b01, 2'b00, 1'b0, 1'b0, 15'h0020, 16'hFFC3, 4);
    do_access("w3_rd_all", 2'd1, 2'b00, 2'b11, 1'b0, 1'b0, 15'h0020, 16'h0000, 4);
  endtask

  task automatic test_back_to_back(input logic [1:0] sl);
    exp_t e;
    int cyc;
    logic got;
    logic [15:1] a;
    logic [15:0] d;
    a = 15'h0066 + 15'(sl);
    d = 16'hC0DE ^ {14'h0, sl};
    sel = sl;
    e.done = 3'b100; e.data = last_rdata[sl]; e.lat = wait_of(sl) + 1;
    sb.push_back(e);
    mdl[sl][a[10:1]] = d;
    e.done = 3'b001; e.data = d; e.lat = wait_of(sl) + 2;
    sb.push_back(e);
    last_rdata[sl] = d;
    @(negedge clk);
    addr = a; wdata = d; wmask = 2'b11; ifetch = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (c_wdone | c_rdone | c_idone) got = 1'b1;
      end
      if (k == 0) wmask = 2'b00;
      else        ifetch = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (!got) begin
        n_fail++; $display("FAIL b2b[%0d] step %0d timeout: no done, required one", sl, k);
      end
      n_checks++;
      if (cyc !== e.lat) begin
        n_fail++; $display("FAIL b2b[%0d] step %0d latency: got %0d required %0d", sl, k, cyc, e.lat);
      end
      n_checks++;
      if ({c_wdone, c_rdone, c_idone} !== e.done) begin
        n_fail++; $display("FAIL b2b[%0d] step %0d done: got %b required %b", sl, k, {c_wdone, c_rdone, c_idone}, e.done);
      end
      n_checks++;
      if (c_rdata !== e.data) begin
        n_fail++; $display("FAIL b2b[%0d] step %0d rdata: got %h required %h", sl, k, c_rdata, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic bad;
    do_access("abort_pre", 2'd2, 2'b11, 2'b00, 1'b0, 1'b0, 15'h0050, 16'h1111, 6);
    @(negedge clk);
    addr = 15'h0050; wdata = 16'h2222; wmask = 2'b11;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drop_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int g = 0; g < 3; g++) last_rdata[g] = 16'h0000;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if ((|wdone_v) || (|rdone_v) || (|idone_v) || (|io_req_v)) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: done/io_req seen after reset, got %b required 0", bad);
    end
    n_checks++;
    if (rdata_v[2] !== 16'h0000) begin
      n_fail++; $display("FAIL abort_rdata: got %h required 0000", rdata_v[2]);
    end
    do_access("abort_post", 2'd2, 2'b00, 2'b11, 1'b0, 1'b0, 15'h0050, 16'h0000, 6);
  endtask

`ifdef MEM_RESPONDER_IO_EN
  task automatic io_quick(input string nm, input logic [1:0] wm, input logic [1:0] rs,
                          input logic [15:1] a, input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    sel = 2'd0;
    e.done = (wm != 2'b00) ? 3'b100 : 3'b010;
    e.data = (wm != 2'b00) ? last_rdata[0] : tb_steer(rs, rd);
    e.lat  = 2;
    last_rdata[0] = e.data;
    sb.push_back(e);
    @(negedge clk);
    io_ready = 1'b1; io_rdata = rd;
    addr = a; wdata = wd; wmask = wm; rstrobe = rs; io_access = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({c_ioreq, c_iowe, c_iowmask, c_ioaddr} !== {1'b1, (wm != 2'b00), wm, a}) begin
      n_fail++; $display("FAIL %s io_bus: got req=%b we=%b wm=%b a=%h required req=1 we=%b wm=%b a=%h",
                         nm, c_ioreq, c_iowe, c_iowmask, c_ioaddr, (wm != 2'b00), wm, a);
    end
    if (wm != 2'b00) begin
      n_checks++;
      if (c_iowdata !== wd) begin
        n_fail++; $display("FAIL %s io_wdata: got %h required %h", nm, c_iowdata, wd);
      end
    end
    @(negedge clk);
    drop_inputs(); io_ready = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({c_wdone, c_rdone, c_idone, c_ioreq} !== {e.done, 1'b0}) begin
      n_fail++; $display("FAIL %s done at min latency: got %b required %b", nm, {c_wdone, c_rdone, c_idone, c_ioreq}, {e.done, 1'b0});
    end
    n_checks++;
    if (c_rdata !== e.data) begin
      n_fail++; $display("FAIL %s rdata: got %h required %h", nm, c_rdata, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_io();
    exp_t e;
    int cyc, req_cnt;
    logic got, stable;
    sel = 2'd0;
    e.done = 3'b010; e.data = 16'hA1B2; e.lat = 7;
    last_rdata[0] = e.data;
    sb.push_back(e);
    @(negedge clk);
    io_ready = 1'b0; io_rdata = 16'h0000;
    addr = 15'h0040; rstrobe = 2'b11; io_access = 1'b1;
    @(posedge clk);
    cyc = 0; req_cnt = 0; got = 1'b0; stable = 1'b1;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      io_ready = 1'b0;
      if (c_ioreq) begin
        req_cnt++;
        if (c_ioaddr !== 15'h0040 || c_iowe !== 1'b0) stable = 1'b0;
        if (req_cnt == 6) begin io_ready = 1'b1; io_rdata = 16'hA1B2; end
      end
      if (c_wdone | c_rdone | c_idone) got = 1'b1;
    end
    drop_inputs(); io_ready = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL io_read timeout: no done, required one");
    end
    n_checks++;
    if (req_cnt !== 6) begin
      n_fail++; $display("FAIL io_read io_req cycles: got %0d required 6", req_cnt);
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL io_read io_addr stable: got %b required 1", stable);
    end
    n_checks++;
    if (cyc !== e.lat || {c_wdone, c_rdone, c_idone} !== e.done) begin
      n_fail++; $display("FAIL io_read done: got lat %0d %b required lat %0d %b", cyc, {c_wdone, c_rdone, c_idone}, e.lat, e.done);
    end
    n_checks++;
    if (c_rdata !== e.data) begin
      n_fail++; $display("FAIL io_read rdata: got %h required %h", c_rdata, e.data);
    end
    @(negedge clk);
    io_quick("io_rd_hi", 2'b00, 2'b10, 15'h0042, 16'h0000, 16'h9C00);
    io_quick("io_write", 2'b01, 2'b00, 15'h0041, 16'h77AA, 16'h0000);
  endtask
`else
  task automatic test_io();
    do_access("io_rd_w0", 2'd0, 2'b00, 2'b11, 1'b0, 1'b1, 15'h0040, 16'h0000, 1);
    n_checks++;
    if (io_seen !== 1'b0) begin
      n_fail++; $display("FAIL io_rd_w0 io_req: got %b required 0", io_seen);
    end
    do_access("io_wr_w0", 2'd0, 2'b11, 2'b00, 1'b0, 1'b1, 15'h0010, 16'hDEAD, 1);
    n_checks++;
    if (io_seen !== 1'b0) begin
      n_fail++; $display("FAIL io_wr_w0 io_req: got %b required 0", io_seen);
    end
    do_access("io_wr_kept", 2'd0, 2'b00, 2'b11, 1'b0, 1'b0, 15'h0010, 16'h0000, 1);
    do_access("io_rd_w3", 2'd1, 2'b00, 2'b11, 1'b0, 1'b1, 15'h0020, 16'h0000, 1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back(2'd0);
    test_back_to_back(2'd1);
    test_io();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameters RV (default 16, data width; only 16 is supported), VA (default RV, virtual address width), AW (default 10, RAM word-address bits), WAIT (default 0, extra RAM latency cycles, 0..7).
REQ-002 SHALL have ports: clk input 1 (clock); reset input 1 (one clock; reset is synchronous and active-low).
REQ-003 SHALL have ports: addr input VA-1 [VA-1:1] (word address); wdata input RV; wmask input 2 (byte write lanes, request when nonzero); rstrobe input 2 (byte read lanes, request when nonzero); ifetch input 1 (instruction fetch request); io_access input 1 (qualifies a read/write as IO).
REQ-004 SHALL have ports: idone output 1; rdone output 1; wdone output 1; rdata output RV.
REQ-005 SHALL have IO-side ports: io_req output 1; io_we output 1; io_addr output VA-1; io_wdata output RV; io_wmask output 2; io_ready input 1; io_rdata input RV.

Function
REQ-006 SHALL contain a 2^AW x RV RAM indexed by addr[AW:1]; higher addr bits SHALL be ignored (aliasing).
REQ-007 SHALL implement FSM states IDLE, BUSY, IOWAIT, DONE.
REQ-008 In IDLE, requests SHALL be sampled with priority write (|wmask) > read (|rstrobe) > ifetch; the winner, addr, wdata, wmask, rstrobe and io_access SHALL be latched.
REQ-009 RAM request: IDLE->BUSY; BUSY SHALL hold WAIT cycles (0 = skip), then DONE; the done pulse SHALL assert exactly WAIT+1 cycles after the sampling edge.
REQ-010 DONE SHALL last exactly one cycle, pulsing exactly one of wdone/rdone/idone matching the latched type, then return to IDLE without sampling requests during DONE.
REQ-011 A RAM write SHALL update only lanes with wmask bit set, committed on the DONE cycle edge.
REQ-012 Read steering: rstrobe 2'b11 -> rdata = full word; 2'b01 -> rdata = {8'h00, word[7:0]}; 2'b10 -> rdata = {8'h00, word[15:8]}.
REQ-013 ifetch SHALL return the full word on rdata with idone; io_access SHALL be ignored for fetches.
REQ-014 rdata SHALL be valid in the done-pulse cycle and SHALL hold its value until the next done pulse.
REQ-015 IO request (io_access=1 with read or write): IDLE->IOWAIT; io_req=1, io_we, io_addr, io_wdata, io_wmask driven from latched values and held stable until io_ready=1 is sampled; then DONE; io_rdata SHALL be lane-steered per REQ-012 and captured on that edge.
REQ-016 io_ready sampled high in the same cycle io_req first rises SHALL complete the access (minimum IO latency 2 cycles).
REQ-017 Requests seen outside IDLE SHALL be ignored; the initiator holds requests level until done.

Reset
REQ-018 While reset=0 at a clk edge: FSM->IDLE; idone, rdone, wdone, io_req, io_we = 0; io_wmask = 0; rdata = 0.
REQ-019 Reset mid-operation SHALL abort the access: no RAM write commits, no done pulse, io_req drops next cycle; RAM contents SHALL NOT be cleared.

Configuration
REQ-020 Macro MEM_RESPONDER_IO_EN: defined -> IO path per REQ-015/016.
REQ-021 Undefined -> IO ports tied 0 (io_req, io_we, io_addr, io_wdata, io_wmask), io_ready/io_rdata unused, IOWAIT state absent; io_access reads complete via DONE one cycle after sampling with rdata=0, io_access writes are dropped with wdone one cycle after sampling; RAM unaffected.

Verification
REQ-022 WAIT=0: write addr=0x10 wdata=0xBEEF wmask=2'b11, then read rstrobe=2'b11 same addr -> wdone 1 cycle after sample, rdone 1 cycle after read sample, rdata=0xBEEF.
REQ-023 WAIT=3: byte write wmask=2'b10 wdata=0x5A5A over word 0x1234, read rstrobe=2'b10 -> wdone at sample+4, rdata=0x005A; rstrobe=2'b01 -> 0x0034.
REQ-024 wmask=2'b11 and ifetch=1 asserted together -> write served first (wdone), idone only after fetch re-sampled in IDLE; never two done pulses in one cycle.
REQ-025 MEM_RESPONDER_IO_EN defined: IO read addr=0x40, io_ready held 0 for 5 cycles then 1 with io_rdata=0xA1B2, rstrobe=2'b11 -> io_req high 6 cycles, io_addr stable, rdone next cycle with rdata=0xA1B2.
REQ-026 WAIT=5 write in BUSY, reset=0 for one cycle -> no wdone, RAM word unchanged, FSM IDLE, all done outputs 0.
REQ-027 MEM_RESPONDER_IO_EN undefined: IO read -> rdone one cycle after sample, rdata=0, io_req stays 0.
